// File: rtl/mux2_burst_arbiter_pkg.sv
// Shared widths, burst limit and arbiter state encodings for the two-requester
// burst arbiter.
package mux2_burst_arbiter_pkg;

  localparam int DATA_BITS = 16;
  localparam int MAX_BURST = 8;
  localparam int CNT_BITS  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_burst_arbiter_mux.sv
// Shared 16-bit 2:1 datapath mux; sel=0 picks data_in1 (requester 0).
module mux2_burst_arbiter_mux
  import mux2_burst_arbiter_pkg::*;
(
  input  logic                 sel,
  input  logic [DATA_BITS-1:0] data_in1,
  input  logic [DATA_BITS-1:0] data_in2,
  output logic [DATA_BITS-1:0] data_out
);

  assign data_out = sel ? data_in2 : data_in1;

endmodule

// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter for two requesters sharing one datapath, with a
// one-stage valid/ready output register.
module mux2_burst_arbiter
  import mux2_burst_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0_valid,
  input  logic [DATA_BITS-1:0] in0_data,
  input  logic                 in0_last,
  output logic                 in0_ready,
  input  logic                 in1_valid,
  input  logic [DATA_BITS-1:0] in1_data,
  input  logic                 in1_last,
  output logic                 in1_ready,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 sel,
  output logic                 busy
);

  arb_state_t           state;
  logic                 last_grant;
  logic [CNT_BITS-1:0]  beat_cnt;
  logic [DATA_BITS-1:0] mux_data;
  logic                 slot_free;
  logic                 accept;
  logic                 beat_last;

  mux2_burst_arbiter_mux u_mux (
    .sel      (sel),
    .data_in1 (in0_data),
    .data_in2 (in1_data),
    .data_out (mux_data)
  );

  // The output slot can take a new beat when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in0_ready = (state == ARB_GNT0) && slot_free;
  assign in1_ready = (state == ARB_GNT1) && slot_free;
  assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign beat_last = ((state == ARB_GNT1) ? in1_last : in0_last) ||
                     (beat_cnt == CNT_BITS'(MAX_BURST - 1));
  assign busy      = (state != ARB_IDLE) || out_valid;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      sel        <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= mux_data;
        out_valid <= 1'b1;
        out_last  <= beat_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          // On a tie the requester that did not hold the last grant wins.
          if (in0_valid && (!in1_valid || last_grant)) begin
            state <= ARB_GNT0;
            sel   <= 1'b0;
          end else if (in1_valid) begin
            state <= ARB_GNT1;
            sel   <= 1'b1;
          end
        end
        ARB_GNT0, ARB_GNT1: begin
          if (accept) begin
            if (beat_last) begin
              state      <= ARB_IDLE;
              beat_cnt   <= '0;
              last_grant <= (state == ARB_GNT1);
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Scenario-driven bench for mux2_burst_arbiter: expected beats are queued per
// scenario and compared against beats collected at the output handshake.
module tb_mux2_burst_arbiter;
  import mux2_burst_arbiter_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        src;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_last, in0_ready;
  logic [15:0] in0_data;
  logic        in1_valid, in1_last, in1_ready;
  logic [15:0] in1_data;
  logic        out_valid, out_last, out_ready, sel, busy;
  logic [15:0] out_data;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];

  mux2_burst_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every beat that leaves through the output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back({out_data, out_last, sel});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_burst(input int idx, input logic [15:0] base,
                             input logic [15:0] step, input int n,
                             input bit with_last, input int gap_at,
                             input int gap_len);
    for (int k = 0; k < n; k++) begin
      logic [15:0] d;
      logic        lst;
      bit          hs;
      int          t;
      d   = base + step * 16'(k);
      lst = with_last && (k == n - 1);
      if (k == gap_at) begin
        if (idx == 0) in0_valid = 1'b0; else in1_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      if (idx == 0) begin
        in0_valid = 1'b1; in0_data = d; in0_last = lst;
      end else begin
        in1_valid = 1'b1; in1_data = d; in1_last = lst;
      end
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = (idx == 0) ? (in0_valid && in0_ready) : (in1_valid && in1_ready);
        t++;
      end
      if (!hs) begin
        checks++; failures++;
        $display("FAIL handshake_timeout req%0d beat %0d: no ready within 200 cycles", idx, k);
      end
      @(posedge clk); #1;
    end
    if (idx == 0) begin in0_valid = 1'b0; in0_last = 1'b0; end
    else          begin in1_valid = 1'b0; in1_last = 1'b0; end
  endtask

  task automatic wait_outputs();
    for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in0_valid = 0; in0_data = '0; in0_last = 0;
    in1_valid = 0; in1_data = '0; in1_last = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({in0_ready, in1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {in1_ready, in0_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int start;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    exp_q.push_back({16'h0011, 1'b0, 1'b0});
    exp_q.push_back({16'h0022, 1'b0, 1'b0});
    exp_q.push_back({16'h0033, 1'b1, 1'b0});
    start = cyc;
    drive_burst(0, 16'h0011, 16'h0011, 3, 1'b1, -1, 0);
    wait_outputs();
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] - start !== 2) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=2", obs_cyc.size() ? obs_cyc[0] - start : -1);
    end
    while (exp_q.size() > 0) begin
      beat_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL single_beat missing exp=%h", e); end
      else begin
        beat_t o;
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL single_beat got={data=%h last=%b sel=%b} exp={data=%h last=%b sel=%b}", o.data, o.last, o.src, e.data, e.last, e.src); end
      end
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    exp_q.push_back({16'h00A1, 1'b0, 1'b0});
    exp_q.push_back({16'h00A2, 1'b1, 1'b0});
    exp_q.push_back({16'h00B1, 1'b0, 1'b1});
    exp_q.push_back({16'h00B2, 1'b1, 1'b1});
    exp_q.push_back({16'h00C1, 1'b0, 1'b0});
    exp_q.push_back({16'h00C2, 1'b1, 1'b0});
    fork
      begin
        drive_burst(0, 16'h00A1, 16'h0001, 2, 1'b1, -1, 0);
        drive_burst(0, 16'h00C1, 16'h0001, 2, 1'b1, -1, 0);
      end
      drive_burst(1, 16'h00B1, 16'h0001, 2, 1'b1, -1, 0);
    join
    wait_outputs();
    checks++;
    if (obs_cyc.size() < 3 || obs_cyc[2] - obs_cyc[1] !== 2) begin
      failures++;
      $display("FAIL tie_gap got=%0d exp=2", obs_cyc.size() >= 3 ? obs_cyc[2] - obs_cyc[1] : -1);
    end
    while (exp_q.size() > 0) begin
      beat_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL tie_beat missing exp=%h", e); end
      else begin
        beat_t o;
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL tie_beat got={data=%h last=%b sel=%b} exp={data=%h last=%b sel=%b}", o.data, o.last, o.src, e.data, e.last, e.src); end
      end
    end
  endtask

  task automatic test_burst_cap();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back({16'h0301 + 16'(k), (k == 7), 1'b1});
    drive_burst(1, 16'h0301, 16'h0001, 12, 1'b0, -1, 0);
    wait_outputs();
    checks++;
    if (obs_cyc.size() < 9 || obs_cyc[8] - obs_cyc[7] !== 2) begin
      failures++;
      $display("FAIL cap_regrant_gap got=%0d exp=2", obs_cyc.size() >= 9 ? obs_cyc[8] - obs_cyc[7] : -1);
    end
    while (exp_q.size() > 0) begin
      beat_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL cap_beat missing exp=%h", e); end
      else begin
        beat_t o;
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL cap_beat got={data=%h last=%b sel=%b} exp={data=%h last=%b sel=%b}", o.data, o.last, o.src, e.data, e.last, e.src); end
      end
    end
    // Requester 1 never closed its second grant; clear it before moving on.
    pulse_reset();
  endtask

  task automatic test_backpressure();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({16'h0211 + 16'h0011 * 16'(k), (k == 3), 1'b0});
    out_ready = 1'b0;
    fork
      drive_burst(0, 16'h0211, 16'h0011, 4, 1'b1, -1, 0);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== 16'h0211 || in0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle %0d got={valid=%b data=%h rdy0=%b} exp={valid=1 data=0211 rdy0=0}", i, out_valid, out_data, in0_ready);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc.size() < 4 || obs_cyc[i+1] - obs_cyc[i] !== 1) begin
        failures++;
        $display("FAIL bp_throughput beat %0d got_spacing=%0d exp=1", i + 1, obs_cyc.size() >= 4 ? obs_cyc[i+1] - obs_cyc[i] : -1);
      end
    end
    while (exp_q.size() > 0) begin
      beat_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL bp_beat missing exp=%h", e); end
      else begin
        beat_t o;
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL bp_beat got={data=%h last=%b sel=%b} exp={data=%h last=%b sel=%b}", o.data, o.last, o.src, e.data, e.last, e.src); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL bp_extra got=%0d extra beats exp=0", obs_q.size()); end
  endtask

  task automatic test_valid_gap();
    bit in0_done;
    int bad;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({16'h0401 + 16'(k), (k == 3), 1'b0});
    exp_q.push_back({16'h0501, 1'b0, 1'b1});
    exp_q.push_back({16'h0502, 1'b1, 1'b1});
    in0_done = 1'b0;
    bad = 0;
    fork
      begin
        drive_burst(0, 16'h0401, 16'h0001, 4, 1'b1, 2, 3);
        in0_done = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        drive_burst(1, 16'h0501, 16'h0001, 2, 1'b1, -1, 0);
      end
      begin
        while (!in0_done) begin
          @(negedge clk);
          if (!in0_done && in1_ready) bad++;
        end
      end
    join
    checks++;
    if (bad != 0) begin failures++; $display("FAIL gap_in1_ready got=%0d cycles ready exp=0", bad); end
    wait_outputs();
    while (exp_q.size() > 0) begin
      beat_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL gap_beat missing exp=%h", e); end
      else begin
        beat_t o;
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL gap_beat got={data=%h last=%b sel=%b} exp={data=%h last=%b sel=%b}", o.data, o.last, o.src, e.data, e.last, e.src); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    out_ready = 1'b0;
    in1_valid = 1'b1; in1_data = 16'h0601; in1_last = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (out_valid !== 1'b1 || sel !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got={valid=%b sel=%b busy=%b} exp={1 1 1}", out_valid, sel, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    in1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sel !== 1'b0 || busy !== 1'b0 || in1_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_post got={valid=%b sel=%b busy=%b rdy1=%b} exp={0 0 0 0}", out_valid, sel, busy, in1_ready);
    end
    @(posedge clk); #1;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    exp_q.push_back({16'h0701, 1'b1, 1'b0});
    exp_q.push_back({16'h0801, 1'b1, 1'b1});
    fork
      drive_burst(0, 16'h0701, 16'h0001, 1, 1'b1, -1, 0);
      drive_burst(1, 16'h0801, 16'h0001, 1, 1'b1, -1, 0);
    join
    wait_outputs();
    while (exp_q.size() > 0) begin
      beat_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL midrst_tie missing exp=%h", e); end
      else begin
        beat_t o;
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL midrst_tie got={data=%h last=%b sel=%b} exp={data=%h last=%b sel=%b}", o.data, o.last, o.src, e.data, e.last, e.src); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_burst_cap();
    test_backpressure();
    test_valid_gap();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
